// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array result path.
package sa_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } drain_state_e;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head word visible combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);
  import sa_pkg::*;

  localparam int unsigned PTR_W = idx_width(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == LVL_W'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign rdata_c = mem[rd_ptr];
  assign level   = count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop) begin
        count <= count + LVL_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/result_drain.sv
// Buffers multiplier result vectors and serialises them one element per beat.
// Optional build macro RESULT_DRAIN_RELU_EN clamps negative elements to zero on load.
module result_drain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COL   = 4,
  parameter int unsigned ROW   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   res_valid_i,
  input  logic [COL*WIDTH-1:0]   res_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_data_o,
  output logic                   out_last_o,
  output logic                   out_tile_last_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o
);
  import sa_pkg::*;

  localparam int unsigned VEC_W  = COL * WIDTH;
  localparam int unsigned LANE_W = idx_width(COL);
  localparam int unsigned ROW_W  = idx_width(ROW);

  drain_state_e      state;
  drain_state_e      state_next;
  logic [VEC_W-1:0]  hold;
  logic [VEC_W-1:0]  hold_next;
  logic [LANE_W-1:0] lane;
  logic [LANE_W-1:0] lane_next;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  row_next;
  logic              valid_next;
  logic [WIDTH-1:0]  data_next;
  logic              last_next;
  logic              tile_last_next;
  logic              overflow_next;

  logic              flush;
  logic              load_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [VEC_W-1:0]  head_c;
  logic [VEC_W-1:0]  head_filt_c;

  assign flush = rst_i || clear_i;

  sync_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .flush   (flush),
    .push    (res_valid_i),
    .wdata   (res_data_i),
    .pop     (load_c),
    .rdata_c (head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .level   (level_o)
  );

`ifdef RESULT_DRAIN_RELU_EN
  // FIFO keeps raw data; negative lanes are zeroed only on the way into the hold register.
  always_comb begin
    head_filt_c = head_c;
    for (int unsigned c = 0; c < COL; c++) begin
      if (head_c[c*WIDTH + WIDTH - 1]) head_filt_c[c*WIDTH +: WIDTH] = '0;
    end
  end
`else
  assign head_filt_c = head_c;
`endif

  // Serialiser next state; outputs are derived from the next lane/row so they register cleanly.
  always_comb begin
    state_next    = state;
    hold_next     = hold;
    lane_next     = lane;
    row_next      = row;
    load_c        = 1'b0;
    overflow_next = overflow_o || (res_valid_i && fifo_full_c);

    case (state)
      IDLE: begin
        if (!fifo_empty_c) begin
          load_c     = 1'b1;
          hold_next  = head_filt_c;
          lane_next  = '0;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          if (lane == LANE_W'(COL - 1)) begin
            row_next  = (row == ROW_W'(ROW - 1)) ? '0 : row + ROW_W'(1);
            lane_next = '0;
            if (!fifo_empty_c) begin
              load_c    = 1'b1;
              hold_next = head_filt_c;
            end else begin
              state_next = IDLE;
            end
          end else begin
            lane_next = lane + LANE_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    valid_next = (state_next == HOLD);
    data_next  = '0;
    if (valid_next) begin
      for (int unsigned c = 0; c < COL; c++) begin
        if (lane_next == LANE_W'(c)) data_next = hold_next[c*WIDTH +: WIDTH];
      end
    end
    last_next      = valid_next && (lane_next == LANE_W'(COL - 1));
    tile_last_next = last_next && (row_next == ROW_W'(ROW - 1));
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state           <= IDLE;
      hold            <= '0;
      lane            <= '0;
      row             <= '0;
      out_valid_o     <= 1'b0;
      out_data_o      <= '0;
      out_last_o      <= 1'b0;
      out_tile_last_o <= 1'b0;
      overflow_o      <= 1'b0;
    end else begin
      state           <= state_next;
      hold            <= hold_next;
      lane            <= lane_next;
      row             <= row_next;
      out_valid_o     <= valid_next;
      out_data_o      <= data_next;
      out_last_o      <= last_next;
      out_tile_last_o <= tile_last_next;
      overflow_o      <= overflow_next;
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: directed table, hand sequences and random traffic vs a queue model.
module tb_result_drain;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned COL   = 4;
  localparam int unsigned ROW   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_data_i = '0;
  logic        out_ready_i = 1'b0;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic        out_tile_last_o;
  logic [2:0]  level_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_drain #(.WIDTH(WIDTH), .COL(COL), .ROW(ROW), .DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .res_valid_i     (res_valid_i),
    .res_data_i      (res_data_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_data_o      (out_data_o),
    .out_last_o      (out_last_o),
    .out_tile_last_o (out_tile_last_o),
    .level_o         (level_o),
    .overflow_o      (overflow_o)
  );

  // Reference model: a queue of vectors plus the vector currently being streamed.
  logic [31:0] mq[$];
  logic        m_busy = 1'b0;
  logic [31:0] m_cur = '0;
  int          m_lane = 0;
  int          m_row = 0;
  logic        m_ovf = 1'b0;

  function automatic logic [7:0] elem(input logic [31:0] v, input int l);
    logic [7:0] e;
    e = v[l*8 +: 8];
`ifdef RESULT_DRAIN_RELU_EN
    if (e[7]) e = 8'h00;
`endif
    return e;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic v,
                            input logic [31:0] d, input logic rdy);
    bit full;
    bit pop;
    if (r || c) begin
      mq.delete();
      m_busy = 1'b0;
      m_lane = 0;
      m_row  = 0;
      m_ovf  = 1'b0;
      return;
    end
    full = (mq.size() == DEPTH);
    pop  = 1'b0;
    if (m_busy && rdy) begin
      if (m_lane == COL - 1) begin
        m_row  = (m_row + 1) % ROW;
        m_lane = 0;
        if (mq.size() > 0) pop = 1'b1;
        else m_busy = 1'b0;
      end else begin
        m_lane++;
      end
    end else if (!m_busy && mq.size() > 0) begin
      pop = 1'b1;
    end
    if (pop) begin
      m_cur  = mq.pop_front();
      m_busy = 1'b1;
      m_lane = 0;
    end
    if (v) begin
      if (full) m_ovf = 1'b1;
      else mq.push_back(d);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance model with the inputs the DUT sampled, then compare after the edge.
  task automatic step();
    logic m_last;
    @(posedge clk);
    model_step(rst_i, clear_i, res_valid_i, res_data_i, out_ready_i);
    #1;
    m_last = m_busy && (m_lane == COL - 1);
    chk("model_valid", 32'(out_valid_o), 32'(m_busy));
    chk("model_data", 32'(out_data_o), m_busy ? 32'(elem(m_cur, m_lane)) : 32'h0);
    chk("model_last", 32'(out_last_o), 32'(m_last));
    chk("model_tile_last", 32'(out_tile_last_o), 32'(m_last && (m_row == ROW - 1)));
    chk("model_level", 32'(level_o), 32'(mq.size()));
    chk("model_overflow", 32'(overflow_o), 32'(m_ovf));
  endtask

  typedef struct {
    logic        rst;
    logic        clr;
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_last;
    logic        e_tile;
    int          e_level;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic clr, input logic v, input logic [31:0] d, input logic rdy,
                     input logic ev, input logic [7:0] ed, input logic el, input logic et,
                     input int elv, input logic eo);
    vec_t t;
    t.rst = 1'b0; t.clr = clr; t.v = v; t.d = d; t.rdy = rdy;
    t.e_valid = ev; t.e_data = ed; t.e_last = el; t.e_tile = et; t.e_level = elv; t.e_ovf = eo;
    tbl.push_back(t);
  endtask

  function automatic logic [31:0] bvec(input int k);
    logic [31:0] v;
    for (int l = 0; l < 4; l++) v[l*8 +: 8] = 8'(k*16 + l);
    return v;
  endfunction

  initial begin
    logic [7:0]  relu2;
    logic [7:0]  relu3;
    logic [31:0] q2;
    int          b;
`ifdef RESULT_DRAIN_RELU_EN
    relu2 = 8'h00; relu3 = 8'h00;
`else
    relu2 = 8'hFF; relu3 = 8'h80;
`endif

    // Reset state
    step();
    step();
    chk("reset_valid", 32'(out_valid_o), 32'h0);
    chk("reset_data", 32'(out_data_o), 32'h0);
    chk("reset_level", 32'(level_o), 32'h0);
    chk("reset_overflow", 32'(overflow_o), 32'h0);
    rst_i = 1'b0;

    // Single vector, ready high
    add(0, 1, 32'h04030201, 1, 0, 8'h00, 0, 0, 1, 0);
    add(0, 0, 32'h0,        1, 1, 8'h01, 0, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1, 8'h02, 0, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1, 8'h03, 0, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1, 8'h04, 1, 0, 0, 0);
    add(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 0);
    // Signed elements, optional clamp
    add(0, 1, 32'h80FF7F00, 1, 0, 8'h00, 0, 0, 1, 0);
    add(0, 0, 32'h0,        1, 1, 8'h00, 0, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1, 8'h7F, 0, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1, relu2, 0, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1, relu3, 1, 0, 0, 0);
    add(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 0);
    // Backpressure: outputs hold while ready is low
    add(0, 1, 32'hDDCCBBAA, 1, 0, 8'h00, 0, 0, 1, 0);
    add(0, 0, 32'h0,        1, 1, 8'hAA, 0, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1, 8'hBB, 0, 0, 0, 0);
    add(0, 0, 32'h0,        0, 1, 8'hBB, 0, 0, 0, 0);
    add(0, 0, 32'h0,        0, 1, 8'hBB, 0, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1, 8'hCC, 0, 0, 0, 0);
    add(0, 0, 32'h0,        0, 1, 8'hCC, 0, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1, 8'hDD, 1, 0, 0, 0);
    add(0, 0, 32'h0,        0, 1, 8'hDD, 1, 0, 0, 0);
    add(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0, 0);
    // Overflow with ready low, then clear
    add(0, 1, 32'h14131211, 0, 0, 8'h00, 0, 0, 1, 0);
    add(0, 1, 32'h24232221, 0, 1, 8'h11, 0, 0, 1, 0);
    add(0, 1, 32'h34333231, 0, 1, 8'h11, 0, 0, 2, 0);
    add(0, 1, 32'h44434241, 0, 1, 8'h11, 0, 0, 3, 0);
    add(0, 1, 32'h54535251, 0, 1, 8'h11, 0, 0, 4, 0);
    add(0, 1, 32'h64636261, 0, 1, 8'h11, 0, 0, 4, 1);
    add(0, 0, 32'h0,        1, 1, 8'h12, 0, 0, 4, 1);
    add(0, 1, 32'h74737271, 0, 1, 8'h12, 0, 0, 4, 1);
    add(1, 0, 32'h0,        0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst_i = tbl[i].rst; clear_i = tbl[i].clr; res_valid_i = tbl[i].v;
      res_data_i = tbl[i].d; out_ready_i = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid_o), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i), 32'(out_data_o), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_last", i), 32'(out_last_o), 32'(tbl[i].e_last));
      chk($sformatf("tbl%0d_tile", i), 32'(out_tile_last_o), 32'(tbl[i].e_tile));
      chk($sformatf("tbl%0d_level", i), 32'(level_o), 32'(tbl[i].e_level));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow_o), 32'(tbl[i].e_ovf));
    end
    clear_i = 1'b0;

    // Reset during lane 2 of the second vector
    q2 = 32'h0D0C0B0A;
    out_ready_i = 1'b1;
    res_valid_i = 1'b1; res_data_i = 32'h05040302; step();
    res_data_i = q2; step();
    res_valid_i = 1'b0;
    repeat (5) step();
    step();
    chk("mid_lane2_data", 32'(out_data_o), 32'h0C);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mid_reset_valid", 32'(out_valid_o), 32'h0);
    chk("mid_reset_data", 32'(out_data_o), 32'h0);
    chk("mid_reset_last", 32'(out_last_o), 32'h0);
    chk("mid_reset_tile", 32'(out_tile_last_o), 32'h0);

    // Back-to-back tile: 16 contiguous beats, tile marker on the last only
    for (int s = 1; s <= 17; s++) begin
      if (s <= 4) begin
        res_valid_i = 1'b1; res_data_i = bvec(s - 1);
      end else begin
        res_valid_i = 1'b0;
      end
      step();
      if (s >= 2) begin
        b = s - 2;
        chk($sformatf("b2b%0d_valid", b), 32'(out_valid_o), 32'h1);
        chk($sformatf("b2b%0d_data", b), 32'(out_data_o), 32'((b / 4) * 16 + (b % 4)));
        chk($sformatf("b2b%0d_last", b), 32'(out_last_o), 32'((b % 4) == 3));
        chk($sformatf("b2b%0d_tile", b), 32'(out_tile_last_o), 32'(b == 15));
      end
    end
    step();
    chk("b2b_end_valid", 32'(out_valid_o), 32'h0);

    // Random traffic against the model
    clear_i = 1'b1; step(); clear_i = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      res_valid_i = ($urandom_range(0, 99) < 45);
      res_data_i  = $urandom;
      out_ready_i = ($urandom_range(0, 99) < 55);
      clear_i     = ($urandom_range(0, 299) == 0);
      rst_i       = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
